// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and constants for the FIFO read-side logic.
//   rd_state_e     - reader FSM states (IDLE, RUN, DRAIN)
//   DEFAULT_DATA_W - default FIFO word width in bits
//   SKID_DEPTH     - entries in the output skid buffer
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned SKID_DEPTH     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry in-order output buffer for the FIFO reader.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push       - write push_data at the tail this edge
//   push_data  - word to enqueue
//   pop        - remove the head word this edge (only asserted when count > 0)
//   head_data  - registered head word (oldest entry)
//   count      - number of valid entries, 0..2
// Entry 0 is always the head, so head_data comes straight from a register.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] ent0_q, ent1_q;
    logic [1:0]        cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            if (push && !pop) begin
                if (cnt_q == 2'd0) begin
                    ent0_q <= push_data;
                end else begin
                    ent1_q <= push_data;
                end
                cnt_q <= cnt_q + 2'd1;
            end else if (!push && pop) begin
                ent0_q <= ent1_q;
                cnt_q  <= cnt_q - 2'd1;
            end else if (push && pop) begin
                // Occupancy unchanged: the new word lands behind whatever remains.
                if (cnt_q == 2'd1) begin
                    ent0_q <= push_data;
                end else begin
                    ent0_q <= ent1_q;
                    ent1_q <= push_data;
                end
            end
        end
    end

    assign head_data = ent0_q;
    assign count     = cnt_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pulls words from a FIFO with 1-cycle read latency and presents
// them on a valid/ready stream through a 2-entry skid buffer.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en        - permit new FIFO reads
//   rd_en     - FIFO pop request (combinational)
//   empty     - FIFO empty flag
//   data_out  - FIFO read data, valid one cycle after rd_en
//   m_data    - downstream word (buffer head)
//   m_valid   - m_data holds a word
//   m_ready   - downstream accepts the word
//   rd_count  - 16-bit wrapping count of delivered words (only when
//               FIFO_READER_CNT_EN is defined)
//   idle      - IDLE state with nothing buffered and no read in flight
// Configuration macro: FIFO_READER_CNT_EN adds rd_count and its counter.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BUF_DEPTH = SKID_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rd_en,
    input  logic              empty,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
`ifdef FIFO_READER_CNT_EN
    output logic [15:0]       rd_count,
`endif
    output logic              idle
);

    rd_state_e  state_q;
    logic       pend_q;
    logic [1:0] count;
    logic       pop;
    logic [2:0] occ_next;

    assign pop = m_valid && m_ready;

    // Occupancy once the in-flight word lands and this cycle's pop retires;
    // a new read is only safe if that leaves room for one more word.
    assign occ_next = {1'b0, count} + {2'b00, pend_q} - {2'b00, pop};

    assign rd_en = !rst && (state_q == RUN) && !empty && (occ_next < 3'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
        end else begin
            pend_q <= rd_en;
            unique case (state_q)
                IDLE: begin
                    if (en) state_q <= RUN;
                end
                RUN: begin
                    if (!en) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (en) begin
                        state_q <= RUN;
                    end else if (!pend_q && (count == 2'd0)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (pend_q),
        .push_data (data_out),
        .pop       (pop),
        .head_data (m_data),
        .count     (count)
    );

    assign m_valid = (count != 2'd0);
    assign idle    = (state_q == IDLE) && (count == 2'd0) && !pend_q;

`ifdef FIFO_READER_CNT_EN
    logic [15:0] rd_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= 16'd0;
        end else if (pop) begin
            rd_count_q <= rd_count_q + 16'd1;
        end
    end

    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed self-checking bench for fifo_reader with a
// behavioural 1-cycle-latency FIFO model. Inputs change on the falling edge,
// outputs are checked on the falling edge.
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rd_en;
    logic       empty;
    logic [7:0] data_out = 8'h00;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       idle;
`ifdef FIFO_READER_CNT_EN
    logic [15:0] rd_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO model
    logic [7:0] fmem [0:63];
    int wptr = 0;
    int rptr = 0;
    assign empty = (rptr == wptr);

    // Activity monitors
    int         n_rd_pulse = 0;
    int         n_pop      = 0;
    logic [7:0] last_pop   = 8'h00;

    always #5 clk = ~clk;

    fifo_reader #(
        .DATA_W    (8),
        .BUF_DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rd_en    (rd_en),
        .empty    (empty),
        .data_out (data_out),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
`ifdef FIFO_READER_CNT_EN
        .rd_count (rd_count),
`endif
        .idle     (idle)
    );

    always @(posedge clk) begin
        if (rd_en) begin
            data_out <= fmem[rptr[5:0]];
            rptr     <= rptr + 1;
            n_rd_pulse <= n_rd_pulse + 1;
        end
        if (m_valid && m_ready) begin
            n_pop    <= n_pop + 1;
            last_pop <= m_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] v);
        fmem[wptr[5:0]] = v;
        wptr = wptr + 1;
    endtask

    task automatic wait_rd_en(input string tag);
        int k = 0;
        while (!rd_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, rd_en}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!idle && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, idle}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, q0;
        rst = 1'b1; en = 1'b0; m_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rd_en",   {31'd0, rd_en},   32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data",  {24'd0, m_data},  32'd0);
        check("rst_idle",    {31'd0, idle},    32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {31'd0, idle}, 32'd1);

        // Full-rate streaming of 0x01..0x08
        for (int i = 1; i <= 8; i++) push_word(8'(i));
        m_ready = 1'b1; en = 1'b1;
        wait_rd_en("fr_first_rd_en");
        @(negedge clk);
        check("fr_lat1_valid", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        check("fr_lat2_valid", {31'd0, m_valid}, 32'd1);
        check("fr_data_1",     {24'd0, m_data},  32'h01);
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            check("fr_valid", {31'd0, m_valid}, 32'd1);
            check("fr_data",  {24'd0, m_data},  32'(i));
        end
        @(negedge clk);
        check("fr_end_valid", {31'd0, m_valid}, 32'd0);
        en = 1'b0;
        wait_idle("fr_idle");

        // Backpressure: two words buffered, a third waiting in the FIFO
        push_word(8'hA5); push_word(8'h5A); push_word(8'h77);
        m_ready = 1'b0; en = 1'b1;
        repeat (8) @(negedge clk);
        check("bp_valid",  {31'd0, m_valid}, 32'd1);
        check("bp_data",   {24'd0, m_data},  32'hA5);
        check("bp_rd_en",  {31'd0, rd_en},   32'd0);
        check("bp_empty",  {31'd0, empty},   32'd0);
        repeat (2) @(negedge clk);
        check("bp_hold",   {24'd0, m_data},  32'hA5);
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_data_2", {24'd0, m_data},  32'h5A);
        @(negedge clk);
        check("bp_data_3", {24'd0, m_data},  32'h77);
        @(negedge clk);
        check("bp_done",   {31'd0, m_valid}, 32'd0);
        en = 1'b0;
        wait_idle("bp_idle");

        // Drain: en drops right after the first rd_en
        push_word(8'h11); push_word(8'h22);
        m_ready = 1'b1; en = 1'b1;
        wait_rd_en("dr_rd_en");
        en = 1'b0;
        @(negedge clk);
        check("dr_no_rd_en", {31'd0, rd_en},   32'd0);
        check("dr_valid0",   {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        check("dr_valid1",   {31'd0, m_valid}, 32'd1);
        check("dr_data",     {24'd0, m_data},  32'h11);
        @(negedge clk);
        check("dr_valid2",   {31'd0, m_valid}, 32'd0);
        check("dr_not_idle", {31'd0, idle},    32'd0);
        @(negedge clk);
        check("dr_idle",     {31'd0, idle},    32'd1);
        repeat (3) begin
            @(negedge clk);
            check("dr_quiet_rd_en", {31'd0, rd_en}, 32'd0);
            check("dr_fifo_left",   {31'd0, empty}, 32'd0);
        end

        // Reset mid-transfer: 0x22 buffered, 0x33 in flight
        push_word(8'h33); push_word(8'h44);
        m_ready = 1'b0; en = 1'b1;
        wait_rd_en("rs_rd_en");
        @(negedge clk);
        check("rs_second_rd", {31'd0, rd_en}, 32'd1);
        @(negedge clk);
        check("rs_buf_head",  {24'd0, m_data}, 32'h22);
        check("rs_full_rd",   {31'd0, rd_en},  32'd0);
        rst = 1'b1;
        check("rs_rd_en_in_rst", {31'd0, rd_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rs_valid", {31'd0, m_valid}, 32'd0);
        check("rs_rd_en", {31'd0, rd_en},   32'd0);
        check("rs_idle",  {31'd0, idle},    32'd1);
        check("rs_data",  {24'd0, m_data},  32'h00);
        m_ready = 1'b1;
        q0 = n_pop;
        begin
            int k = 0;
            while (!m_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        check("rs_next_data", {24'd0, m_data}, 32'h44);
        @(negedge clk);
        check("rs_after_valid", {31'd0, m_valid}, 32'd0);
        en = 1'b0;
        wait_idle("rs_idle_end");
        check("rs_pop_count", 32'(n_pop - q0), 32'd1);

        // Empty boundary
        en = 1'b1; m_ready = 1'b1;
        p0 = n_rd_pulse; q0 = n_pop;
        repeat (6) begin
            @(negedge clk);
            check("em_rd_en",  {31'd0, rd_en},   32'd0);
            check("em_valid",  {31'd0, m_valid}, 32'd0);
        end
        push_word(8'h3C);
        repeat (6) @(negedge clk);
        check("em_one_rd",  32'(n_rd_pulse - p0), 32'd1);
        check("em_one_pop", 32'(n_pop - q0),      32'd1);
        check("em_word",    {24'd0, last_pop},    32'h3C);
        en = 1'b0;
        wait_idle("em_idle");

`ifdef FIFO_READER_CNT_EN
        // Counter wrap after 65536 pops
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("cnt_rst", {16'd0, rd_count}, 32'd0);
        en = 1'b1; m_ready = 1'b1;
        q0 = n_pop;
        wptr = wptr + 65536;
        begin
            int   k    = 0;
            logic seen = 1'b0;
            while ((n_pop - q0) < 65536 && k < 70000) begin
                @(negedge clk);
                k++;
                if (!seen && (n_pop - q0) == 65535) begin
                    seen = 1'b1;
                    check("cnt_ffff", {16'd0, rd_count}, 32'h0000FFFF);
                end
            end
            check("cnt_seen_ffff", {31'd0, seen}, 32'd1);
        end
        check("cnt_pops", 32'(n_pop - q0), 32'd65536);
        check("cnt_wrap", {16'd0, rd_count}, 32'd0);
        en = 1'b0;
        wait_idle("cnt_idle");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the FIFO data width in bits.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, the number of output buffer entries; only the value 2 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: 1 permits new FIFO reads.
REQ-006 SHALL have port rd_en, output, 1 bit: FIFO pop request.
REQ-007 SHALL have port empty, input, 1 bit: FIFO empty flag.
REQ-008 SHALL have port data_out, input, DATA_W bits: FIFO read data, valid exactly 1 cycle after rd_en is sampled high.
REQ-009 SHALL have port m_data, output, DATA_W bits: downstream data.
REQ-010 SHALL have port m_valid, output, 1 bit: m_data holds a word.
REQ-011 SHALL have port m_ready, input, 1 bit: downstream accepts the word.
REQ-012 SHALL have port idle, output, 1 bit: high in state IDLE with nothing buffered and no read in flight.

Function
REQ-013 SHALL drive rd_en combinationally as: not rst, state RUN, empty low, and (occupancy + pend - pop) < 2.
- pop = m_valid and m_ready.
REQ-014 SHALL set pend, a 1-bit in-flight flag, to the value of rd_en on every clock edge.
REQ-015 SHALL capture data_out into the tail of a 2-entry in-order buffer on every edge where pend is 1; the capture happens regardless of the current value of empty.
REQ-016 SHALL drive m_valid high whenever occupancy > 0 and drive m_data from the buffer head, both from registers.
REQ-017 SHALL hold m_data stable while m_valid is high and m_ready is low.
REQ-018 SHALL, on an edge with a capture and a pop together, leave occupancy unchanged and keep word order.
REQ-019 SHALL sustain one word per cycle when empty stays low and m_ready stays high; the latency from the first rd_en to m_valid is 2 cycles.
REQ-020 SHALL implement the FSM states IDLE, RUN and DRAIN.
- IDLE to RUN when en=1.
- RUN to DRAIN when en=0.
- DRAIN to RUN when en=1.
- DRAIN to IDLE when pend=0 and occupancy=0.
REQ-021 SHALL issue no rd_en in IDLE or DRAIN, and SHALL still complete an in-flight read and deliver buffered words in DRAIN.
REQ-022 SHALL never drop or duplicate a word, and SHALL never exceed occupancy 2.
- When empty toggles every cycle, rd_en tracks the current value of empty only.

Reset
REQ-023 SHALL set the following on rst: state=IDLE, pend=0, occupancy=0, rd_en=0, m_valid=0, m_data=0, idle=1.
- Any read in flight is discarded.
REQ-024 SHALL give rst priority over every other input, including a mid-transfer or stalled output.

Configuration
REQ-025 SHALL, when macro FIFO_READER_CNT_EN is defined, add a 16-bit output rd_count.
- rd_count resets to 0.
- rd_count increments on each pop.
- rd_count wraps from 16'hFFFF to 0.
REQ-026 SHALL, when FIFO_READER_CNT_EN is undefined, have neither the port rd_count nor its counter logic.

Structure
REQ-027 SHALL take the FSM state enum (rd_state_e) and the default data-width constant from shared package fifo_pkg.
REQ-028 SHALL place the 2-entry buffer in sub-module fifo_rd_skid (ports: push, push_data, pop, head_data, count).

Verification
REQ-029 SHALL cover full-rate streaming:
- Stimulus: en=1, m_ready=1, FIFO preloaded with 0x01..0x08.
- Required: m_data emits 0x01..0x08 on 8 consecutive cycles; first m_valid 2 cycles after the first rd_en.
REQ-030 SHALL cover backpressure:
- Stimulus: m_ready=0 with 0xA5, 0x5A queued.
- Required: occupancy 2, rd_en=0, m_data held at 0xA5.
- Then m_ready=1: 0xA5 then 0x5A are emitted with no loss.
REQ-031 SHALL cover drain:
- Stimulus: en deasserted the cycle after rd_en.
- Required: the in-flight word is still delivered, then state IDLE and idle=1 with no further rd_en.
REQ-032 SHALL cover reset mid-transfer:
- Stimulus: rst pulsed with occupancy 2 and pend=1.
- Required: next cycle m_valid=0, rd_en=0, idle=1; the FIFO word read before reset is never emitted.
REQ-033 SHALL cover the empty boundary:
- Stimulus: empty=1 throughout with en=1.
- Required: rd_en stays 0 and m_valid stays 0.
- Then a single word 0x3C: exactly one rd_en pulse and one 0x3C delivered.
REQ-034 SHALL cover the counter, with FIFO_READER_CNT_EN defined:
- Stimulus: rd_count preset via 65,536 pops.
- Required: rd_count wraps to 0.
